i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target_pkg.sv | 20 ++
 rtl/i2c_bus_sync.sv | 43 ++++
 rtl/i2c_target.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/i2c_target_pkg.sv
// Shared constants and state encoding for the I2C register-access target.
package i2c_target_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk_50m and flags SCL edges plus START/STOP.
module i2c_bus_sync (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;

    // Two synchronizer flops plus one history flop per line; idle bus level is 1
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= scl;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign sda_s     = sda_p1;
    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    // SDA may only move while SCL is steadily high for a bus condition
    assign start_det = scl_p1 & scl_p2 &  sda_p2 & ~sda_p1;
    assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 &  sda_p1;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing an 8-bit register pointer with write/read strobes.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR = 7'h1A
) (
    input  logic                  clk_50m,
    input  logic                  rst_n,
    input  logic                  SCL,
    inout  wire                   SDA,
    output logic [I2C_BYTE_W-1:0] reg_addr,
    output logic [I2C_BYTE_W-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [I2C_BYTE_W-1:0] reg_rdata,
    output logic                  busy
);

    state_t                  state, state_next;
    logic                    sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]              bit_cnt;
    logic [I2C_BYTE_W-1:0]   shift, tx;
    logic [I2C_BYTE_W-1:0]   byte_in;
    logic                    rw, re_dly;
    logic                    sda_low, sda_low_nxt, we_nxt, re_nxt;
    logic                    bus_evt, byte_done, is_ack;

    i2c_bus_sync u_sync (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .scl       (SCL),
        .sda       (SDA),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Open-drain: only ever pull low
    assign SDA       = sda_low ? 1'b0 : 1'bz;
    assign byte_in   = {shift[I2C_BYTE_W-2:0], sda_s};
    assign bus_evt   = start_det | stop_det;
    assign byte_done = scl_rise && (bit_cnt == 4'd7);
    assign is_ack    = (state == ST_ADDR_ACK) || (state == ST_PTR_ACK) || (state == ST_WDATA_ACK);

    // State register
    always_ff @(posedge clk_50m) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; bus conditions override any bit processing.
    // ACK states use bit_cnt 0/1 to tell the first SCL fall from the second.
    always_comb begin
        state_next = state;
        if (start_det) begin
            state_next = ST_ADDR;
        end else if (stop_det) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_ADDR:      if (byte_done) state_next = (byte_in[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
                ST_ADDR_ACK:  if (scl_fall && bit_cnt == 4'd1) state_next = rw ? ST_RDATA : ST_PTR;
                ST_PTR:       if (byte_done) state_next = ST_PTR_ACK;
                ST_PTR_ACK:   if (scl_fall && bit_cnt == 4'd1) state_next = ST_WDATA;
                ST_WDATA:     if (byte_done) state_next = ST_WDATA_ACK;
                ST_WDATA_ACK: if (scl_fall && bit_cnt == 4'd1) state_next = ST_WDATA;
                ST_RDATA:     if (scl_fall && bit_cnt == 4'd8) state_next = ST_RDATA_ACK;
                ST_RDATA_ACK: if (scl_fall && bit_cnt == 4'd1) state_next = shift[0] ? ST_WAIT_STOP : ST_RDATA;
                default:      state_next = state;
            endcase
        end
    end

    // Output decode: SDA drive level and register strobes for the next cycle
    always_comb begin
        sda_low_nxt = sda_low;
        we_nxt      = 1'b0;
        re_nxt      = 1'b0;
        if (bus_evt) begin
            sda_low_nxt = 1'b0;
        end else begin
            unique case (state)
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK:
                    if (scl_fall) sda_low_nxt = (bit_cnt == 4'd0);
                ST_RDATA:
                    if (re_dly)        sda_low_nxt = ~reg_rdata[7];
                    else if (scl_fall) sda_low_nxt = (bit_cnt == 4'd8) ? 1'b0 : ~tx[6];
                default:
                    sda_low_nxt = 1'b0;
            endcase
            we_nxt = (state == ST_WDATA) && byte_done;
            re_nxt = (state_next == ST_RDATA) && (state != ST_RDATA);
        end
    end

    // Control registers: bit counter, pointer, strobes, busy, SDA drive
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            bit_cnt   <= 4'd0;
            rw        <= 1'b0;
            re_dly    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            sda_low   <= 1'b0;
        end else begin
            if (bus_evt || state_next != state)
                bit_cnt <= 4'd0;
            else if (scl_rise && (state == ST_ADDR || state == ST_PTR || state == ST_WDATA ||
                                  state == ST_RDATA || state == ST_RDATA_ACK))
                bit_cnt <= bit_cnt + 4'd1;
            else if (scl_fall && is_ack)
                bit_cnt <= bit_cnt + 4'd1;

            if (state == ST_ADDR && byte_done) rw <= sda_s;

            // Pointer load, post-write increment (cycle after reg_we), post-read increment
            if (!bus_evt && state == ST_PTR_ACK && scl_fall && bit_cnt == 4'd0)
                reg_addr <= shift;
            else if (reg_we)
                reg_addr <= reg_addr + 8'd1;
            else if (!bus_evt && state == ST_RDATA && scl_fall && bit_cnt == 4'd8)
                reg_addr <= reg_addr + 8'd1;

            if (we_nxt) reg_wdata <= byte_in;
            reg_we  <= we_nxt;
            reg_re  <= re_nxt;
            re_dly  <= reg_re;
            sda_low <= sda_low_nxt;

            if (state_next == ST_IDLE)
                busy <= 1'b0;
            else if (state == ST_ADDR && state_next == ST_ADDR_ACK)
                busy <= 1'b1;
        end
    end

    // Data shifters: RX byte assembly and TX byte serialisation
    always_ff @(posedge clk_50m) begin
        if (scl_rise && (state == ST_ADDR || state == ST_PTR || state == ST_WDATA || state == ST_RDATA_ACK))
            shift <= byte_in;
        if (re_dly)
            tx <= reg_rdata;
        else if (state == ST_RDATA && scl_fall && bit_cnt != 4'd8)
            tx <= {tx[6:0], 1'b0};
    end

endmodule
